// File: rtl/t03_sfr_pkg.sv
// Shared types and defaults for the serial frame receiver.
// Optional feature macro used by this slice: T03_SFR_PARITY_EN.
package t03_sfr_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  localparam int          SFR_WIDTH_DEF     = 8;
  localparam logic [31:0] SFR_RESET_VAL_DEF = '1;

endpackage

// File: rtl/t03_serial_frame_rx_if.sv
// Handshake bundle between the serial frame receiver and its driver/consumer.
// parity_err exists only when T03_SFR_PARITY_EN is defined.
interface t03_serial_frame_rx_if
  import t03_sfr_pkg::*;
#(
  parameter int WIDTH = SFR_WIDTH_DEF
) ();

  localparam int CNT_W = $clog2(WIDTH + 2);

  logic             shift_en;
  logic             data_in;
  logic             frame_end;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [CNT_W-1:0] bit_count;
  logic             overrun;
`ifdef T03_SFR_PARITY_EN
  logic             parity_err;
`endif

  modport master (
    output shift_en,
    output data_in,
    output frame_end,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  bit_count,
    input  overrun
`ifdef T03_SFR_PARITY_EN
    ,
    input  parity_err
`endif
  );

  modport slave (
    input  shift_en,
    input  data_in,
    input  frame_end,
    input  out_ready,
    output out_data,
    output out_valid,
    output bit_count,
    output overrun
`ifdef T03_SFR_PARITY_EN
    ,
    output parity_err
`endif
  );

endinterface

// File: rtl/t03_sfr_shift_core.sv
// Shift register, bit counter and frame-completion detect for the receiver.
// Extra parity-related outputs exist only when T03_SFR_PARITY_EN is defined.
module t03_sfr_shift_core #(
  parameter int               WIDTH      = 8,
  parameter int               MSB_FIRST  = 1,
  parameter int               FRAME_BITS = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = '1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          shift_en,
  input  logic                          data_in,
  input  logic                          frame_end,
  output logic [WIDTH-1:0]              sr_next,
  output logic [$clog2(WIDTH+2)-1:0]    bit_count,
  output logic                          complete
`ifdef T03_SFR_PARITY_EN
  ,
  output logic                          full_frame,
  output logic                          payload_par
`endif
);

  localparam int               CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] PAY_CNT  = CNT_W'(WIDTH);

  logic [WIDTH-1:0] sr_q;
  logic             shift_payload;
  logic             last_bit;

  // A trailing parity bit (count == WIDTH) is counted but never enters sr.
  always_comb begin
    shift_payload = shift_en && (bit_count < PAY_CNT);
    sr_next       = sr_q;
    if (shift_payload) begin
      if (MSB_FIRST != 0) sr_next = {sr_q[WIDTH-2:0], data_in};
      else                sr_next = {data_in, sr_q[WIDTH-1:1]};
    end
    last_bit = shift_en && (bit_count == LAST_CNT);
    complete = last_bit || (frame_end && ((bit_count != '0) || shift_en));
  end

`ifdef T03_SFR_PARITY_EN
  assign full_frame  = last_bit;
  assign payload_par = ^sr_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q      <= RESET_VAL;
      bit_count <= '0;
    end else begin
      sr_q <= sr_next;
      if (complete)      bit_count <= '0;
      else if (shift_en) bit_count <= bit_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/t03_serial_frame_rx.sv
// Serial frame receiver: deserialises bits into frames and hands them out
// through a one-deep valid/ready holding register. Optional: T03_SFR_PARITY_EN.
module t03_serial_frame_rx
  import t03_sfr_pkg::*;
#(
  parameter int               WIDTH     = SFR_WIDTH_DEF,
  parameter int               MSB_FIRST = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = SFR_RESET_VAL_DEF[WIDTH-1:0]
) (
  input logic                   clk,
  input logic                   rst,
  t03_serial_frame_rx_if.slave  bus
);

`ifdef T03_SFR_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif

  localparam logic [0:0] ST_EMPTY = EMPTY;
  localparam logic [0:0] ST_FULL  = FULL;

  logic [WIDTH-1:0] sr_next;
  logic             complete;
  logic             load;
  logic [0:0]       state_q;
  logic [WIDTH-1:0] out_data_q;
  logic             overrun_q;
`ifdef T03_SFR_PARITY_EN
  logic             full_frame;
  logic             payload_par;
  logic             parity_err_q;
`endif

  t03_sfr_shift_core #(
    .WIDTH      (WIDTH),
    .MSB_FIRST  (MSB_FIRST),
    .FRAME_BITS (FRAME_BITS),
    .RESET_VAL  (RESET_VAL)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .shift_en   (bus.shift_en),
    .data_in    (bus.data_in),
    .frame_end  (bus.frame_end),
    .sr_next    (sr_next),
    .bit_count  (bus.bit_count),
    .complete   (complete)
`ifdef T03_SFR_PARITY_EN
    ,
    .full_frame (full_frame),
    .payload_par(payload_par)
`endif
  );

  // A completed frame is accepted only if the holder is empty or being drained.
  assign load = complete && ((state_q == ST_EMPTY) || bus.out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      out_data_q <= RESET_VAL;
      overrun_q  <= 1'b0;
    end else begin
      if (load) out_data_q <= sr_next;
      if (complete && (state_q == ST_FULL) && !bus.out_ready) overrun_q <= 1'b1;
      case (state_q)
        ST_EMPTY: if (complete) state_q <= ST_FULL;
        ST_FULL:  if (bus.out_ready && !complete) state_q <= ST_EMPTY;
        default:  state_q <= ST_EMPTY;
      endcase
    end
  end

`ifdef T03_SFR_PARITY_EN
  // Frames cut short by frame_end never carried a parity bit, so flag them.
  always_ff @(posedge clk) begin
    if (rst)       parity_err_q <= 1'b0;
    else if (load) parity_err_q <= full_frame ? (payload_par ^ bus.data_in) : 1'b1;
  end
  assign bus.parity_err = parity_err_q;
`endif

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.overrun   = overrun_q;

endmodule

// File: doc/t03_serial_frame_rx.md
T03_SERIAL_FRAME_RX -- requirements
Module: t03_serial_frame_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, frame payload width in bits (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = first received bit ends in out_data[WIDTH-1], 0 = first received bit ends in out_data[0].
REQ-003 SHALL have parameter RESET_VAL, default all ones, WIDTH bits, reset content of the shift register and out_data.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port shift_en  input  1  sample data_in this cycle.
REQ-007 SHALL have port data_in  input  1  serial data bit.
REQ-008 SHALL have port frame_end  input  1  force completion of a short frame.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-010 SHALL have port out_data  output  WIDTH  latched frame, registered.
REQ-011 SHALL have port out_valid  output  1  out_data holds an unconsumed frame.
REQ-012 SHALL have port bit_count  output  $clog2(WIDTH+2)  bits received in the current frame.
REQ-013 SHALL have port overrun  output  1  sticky: a completed frame was dropped.

Function
REQ-014 On shift_en: MSB_FIRST=1 shifts {sr[WIDTH-2:0],data_in}; MSB_FIRST=0 shifts {data_in,sr[WIDTH-1:1]}; bit_count increments by 1.
REQ-015 Frame completes in the cycle where shift_en brings bit_count to FRAME_BITS (WIDTH, or WIDTH+1 per REQ-026), or where frame_end=1 with bit_count>0 or shift_en=1.
REQ-016 On completion, the next-state shift register value, including any bit shifted that cycle, SHALL load out_data one edge later; bit_count returns to 0; latency from the final bit's edge to out_valid=1 is 0 extra cycles.
REQ-017 frame_end with bit_count=0 and shift_en=0 SHALL be ignored.
REQ-018 Short frame: unfilled shift-register positions retain prior contents; no zero fill.
REQ-019 Output FSM, two states: EMPTY (out_valid=0) and FULL (out_valid=1). EMPTY->FULL on completion. FULL->EMPTY on out_ready with no completion. FULL->FULL on completion with out_ready (new frame loaded).
REQ-020 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 Completion in FULL with out_ready=0 SHALL drop the new frame, keep out_data, set overrun; bit_count still returns to 0.
REQ-022 overrun clears only on rst.

Reset
REQ-023 rst=1 at a rising edge SHALL set sr=RESET_VAL, out_data=RESET_VAL, out_valid=0, bit_count=0, overrun=0, and parity_err=0 when present; rst overrides all other inputs.
REQ-024 A partial frame in flight at reset SHALL be discarded without producing out_valid.

Configuration
REQ-025 Macro T03_SFR_PARITY_EN SHALL compile in parity checking; without it, FRAME_BITS=WIDTH and port parity_err is absent.
REQ-026 With the macro: FRAME_BITS=WIDTH+1; the final bit is an even-parity bit, not shifted into sr; output parity_err (1 bit) loads with out_data and is 1 when the XOR of payload and parity bit is 1; a frame_end-terminated frame SHALL load parity_err=1.

Structure
REQ-027 Package t03_sfr_pkg SHALL hold the output-state enum (EMPTY, FULL) and default constants for WIDTH and RESET_VAL.
REQ-028 Sub-module t03_sfr_shift_core SHALL contain the shift register, bit counter and completion detect; the top level holds the output FSM, out_data, overrun and parity.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1: shift 1,0,1,1,0,0,1,0 with out_ready=0 -> out_data=8'hB2, out_valid=1 on the edge of bit 8; bit_count=0.
REQ-030 MSB_FIRST=0, same bits -> out_data=8'h4D.
REQ-031 Three bits 1,1,0, then frame_end -> MSB_FIRST=1 out_data=8'hFE from reset sr=8'hFF; bit_count=0.
REQ-032 Frame held with out_ready=0, second full frame completes -> out_data unchanged, overrun=1; with out_ready=1 on the completing cycle -> new data loaded, overrun stays 0.
REQ-033 rst asserted after bit 5 -> out_valid=0, bit_count=0, out_data=8'hFF; the next 8 bits form a fresh frame.
REQ-034 With T03_SFR_PARITY_EN: payload 8'hB2 plus parity bit 0 -> parity_err=0; plus parity bit 1 -> parity_err=1.
